// File: rtl/hpi_driver_pkg.sv
// Shared constants and helpers for the HPI driver register slave and its gap monitors.
package hpi_driver_pkg;

    localparam int unsigned GAP_W     = 16;
    localparam int unsigned NBINS     = 16;
    localparam int unsigned BIN_W     = $clog2(NBINS);
    localparam int unsigned BIN_SHIFT = 3;
    localparam int unsigned HIST_LSB  = BIN_W + 2;

    localparam logic [31:0] REG_PUSH       = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL       = 32'h0000_0004;
    localparam logic [31:0] REG_ADDR_TOTAL = 32'h0000_0100;
    localparam logic [31:0] REG_VCTR_TOTAL = 32'h0000_0104;
    localparam logic [31:0] REG_ADDR_OCC   = 32'h0000_0108;
    localparam logic [31:0] REG_VCTR_MAX   = 32'h0000_010C;
    localparam logic [31:0] REG_VCTR_OCC   = 32'h0000_0110;
    localparam logic [31:0] ADDR_HIST_BASE = 32'h0001_1000;
    localparam logic [31:0] VCTR_HIST_BASE = 32'h0001_2000;

    // Gaps past the last bin's range all land in the last bin.
    function automatic logic [BIN_W-1:0] gap_bin(input logic [GAP_W-1:0] gap);
        logic [GAP_W-1:0] idx;
        idx = gap >> BIN_SHIFT;
        if (idx > GAP_W'(NBINS - 1)) begin
            return BIN_W'(NBINS - 1);
        end
        return idx[BIN_W-1:0];
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] occ_next(input logic [31:0] occ, input logic push,
                                             input logic pop);
        if (push && !pop) begin
            return sat_inc32(occ);
        end
        if (pop && !push && (occ != '0)) begin
            return occ - 32'd1;
        end
        return occ;
    endfunction

endpackage

// File: rtl/gap_monitor.sv
// Inter-event gap tracker: saturating gap counter, armed flag, gap histogram and max gap.
module gap_monitor
    import hpi_driver_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             evt,
    input  logic [BIN_W-1:0] rd_bin,
    input  logic             rd_max,
    output logic [GAP_W-1:0] rd_data
);

    localparam logic [GAP_W-1:0] GAP_SAT = '1;

    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] max_q, max_d;
    logic [GAP_W-1:0] meas_gap;
    logic             armed_q, armed_d;
    logic [GAP_W-1:0] bin_q [NBINS];
    logic [GAP_W-1:0] bin_d [NBINS];
    logic [BIN_W-1:0] hit_bin;

    always_comb begin
        // gap_q excludes the event cycle itself, so the measured distance is one more.
        meas_gap = (gap_q == GAP_SAT) ? GAP_SAT : gap_q + GAP_W'(1);
        hit_bin  = gap_bin(meas_gap);
        gap_d    = gap_q;
        armed_d  = armed_q;
        max_d    = max_q;
        bin_d    = bin_q;
        if (evt) begin
            gap_d   = '0;
            armed_d = 1'b1;
            if (armed_q) begin
                if (bin_q[hit_bin] != GAP_SAT) begin
                    bin_d[hit_bin] = bin_q[hit_bin] + GAP_W'(1);
                end
                if (meas_gap > max_q) begin
                    max_d = meas_gap;
                end
            end
        end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            gap_q   <= '0;
            max_q   <= '0;
            armed_q <= 1'b0;
            bin_q   <= '{default: '0};
        end else begin
            gap_q   <= gap_d;
            max_q   <= max_d;
            armed_q <= armed_d;
            bin_q   <= bin_d;
        end
    end

    assign rd_data = rd_max ? max_q : bin_q[rd_bin];

endmodule

// File: rtl/hpi_driver.sv
// Register slave that pushes host-written addresses to the address FIFO and monitors
// address/vector FIFO traffic (totals, occupancies, gap histograms, max vector gap).
module hpi_driver
    import hpi_driver_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] slave_addr,
    input  logic        slave_rd,
    input  logic        slave_wr,
    input  logic [31:0] slave_data_in,
    output logic [31:0] slave_data_out,
    output logic [31:0] addr_fifo_din,
    output logic        addr_fifo_wr,
    input  logic        addr_fifo_rd,
    input  logic        vctr_fifo_wr,
    input  logic        vctr_fifo_rd
);

    logic             push_wr, ctrl_wr;
    logic             fifo_wr_q;
    logic [31:0]      din_q;
    logic             ctrl_q;
    logic [31:0]      addr_total_q, vctr_total_q;
    logic [31:0]      addr_occ_q, vctr_occ_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             addr_hist_hit, vctr_hist_hit;
    logic [GAP_W-1:0] addr_mon_data, vctr_mon_data;

    assign push_wr = slave_wr && (slave_addr == REG_PUSH);
    assign ctrl_wr = slave_wr && (slave_addr == REG_CTRL);

    assign addr_hist_hit = (slave_addr[31:HIST_LSB] == ADDR_HIST_BASE[31:HIST_LSB])
                           && (slave_addr[1:0] == 2'b00);
    assign vctr_hist_hit = (slave_addr[31:HIST_LSB] == VCTR_HIST_BASE[31:HIST_LSB])
                           && (slave_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr_q <= 1'b0;
            din_q     <= '0;
            ctrl_q    <= 1'b0;
        end else begin
            fifo_wr_q <= push_wr;
            if (push_wr) begin
                din_q <= slave_data_in;
            end
            if (ctrl_wr) begin
                ctrl_q <= slave_data_in[0];
            end
        end
    end

    // Statistics follow the actual push pulse, so a push is counted the cycle it reaches the FIFO.
    always_ff @(posedge clk) begin
        if (reset || ctrl_q) begin
            addr_total_q <= '0;
            vctr_total_q <= '0;
            addr_occ_q   <= '0;
            vctr_occ_q   <= '0;
        end else begin
            if (fifo_wr_q) begin
                addr_total_q <= sat_inc32(addr_total_q);
            end
            if (vctr_fifo_wr) begin
                vctr_total_q <= sat_inc32(vctr_total_q);
            end
            addr_occ_q <= occ_next(addr_occ_q, fifo_wr_q, addr_fifo_rd);
            vctr_occ_q <= occ_next(vctr_occ_q, vctr_fifo_wr, vctr_fifo_rd);
        end
    end

    gap_monitor u_addr_gap (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctrl_q),
        .evt     (fifo_wr_q),
        .rd_bin  (slave_addr[2 +: BIN_W]),
        .rd_max  (1'b0),
        .rd_data (addr_mon_data)
    );

    gap_monitor u_vctr_gap (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctrl_q),
        .evt     (vctr_fifo_wr),
        .rd_bin  (slave_addr[2 +: BIN_W]),
        .rd_max  (slave_addr == REG_VCTR_MAX),
        .rd_data (vctr_mon_data)
    );

    always_comb begin
        rdata_d = '0;
        if (addr_hist_hit) begin
            rdata_d = 32'(addr_mon_data);
        end else if (vctr_hist_hit) begin
            rdata_d = 32'(vctr_mon_data);
        end else begin
            case (slave_addr)
                REG_PUSH:       rdata_d = din_q;
                REG_CTRL:       rdata_d = {31'b0, ctrl_q};
                REG_ADDR_TOTAL: rdata_d = addr_total_q;
                REG_VCTR_TOTAL: rdata_d = vctr_total_q;
                REG_ADDR_OCC:   rdata_d = addr_occ_q;
                REG_VCTR_MAX:   rdata_d = 32'(vctr_mon_data);
                REG_VCTR_OCC:   rdata_d = vctr_occ_q;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (slave_rd) begin
            rdata_q <= rdata_d;
        end
    end

    assign slave_data_out = rdata_q;
    assign addr_fifo_din  = din_q;
    assign addr_fifo_wr   = fifo_wr_q;

endmodule

// File: tb/tb_hpi_driver.sv
// Bench for hpi_driver: directed and randomized traffic checked against an event-time model
// through read-data and push-data scoreboards.
module tb_hpi_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] slave_addr;
    logic        slave_rd;
    logic        slave_wr;
    logic [31:0] slave_data_in;
    logic [31:0] slave_data_out;
    logic [31:0] addr_fifo_din;
    logic        addr_fifo_wr;
    logic        addr_fifo_rd;
    logic        vctr_fifo_wr;
    logic        vctr_fifo_rd;

    always #5 clk = ~clk;

    hpi_driver dut (
        .clk            (clk),
        .reset          (reset),
        .slave_addr     (slave_addr),
        .slave_rd       (slave_rd),
        .slave_wr       (slave_wr),
        .slave_data_in  (slave_data_in),
        .slave_data_out (slave_data_out),
        .addr_fifo_din  (addr_fifo_din),
        .addr_fifo_wr   (addr_fifo_wr),
        .addr_fifo_rd   (addr_fifo_rd),
        .vctr_fifo_wr   (vctr_fifo_wr),
        .vctr_fifo_rd   (vctr_fifo_rd)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        bit          cv;
        logic [31:0] cval;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] din_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        rd_due = 1'b0;
    rd_exp_t     mon_e;
    logic [31:0] mon_d;

    // Reference model: event times and unbounded counts, clamped when read.
    longint      cyc = 0;
    bit          m_ctrl = 0;
    bit          m_pend = 0;
    logic [31:0] m_din = '0;
    longint      m_atot, m_vtot, m_aocc, m_vocc, m_vmax;
    longint      m_abin[16];
    longint      m_vbin[16];
    longint      m_alast = -1;
    longint      m_vlast = -1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] clamp(input longint x, input longint lim);
        longint v;
        v = (x > lim) ? lim : x;
        return v[31:0];
    endfunction

    function automatic int bin_of(input longint g);
        return (g / 8 > 15) ? 15 : int'(g / 8);
    endfunction

    function automatic longint occ(input longint o, input bit push, input bit pop);
        if (push && !pop) return o + 1;
        if (pop && !push) return (o > 0) ? o - 1 : 0;
        return o;
    endfunction

    function automatic void clear_stats();
        m_atot = 0; m_vtot = 0; m_aocc = 0; m_vocc = 0; m_vmax = 0;
        m_alast = -1; m_vlast = -1;
        for (int b = 0; b < 16; b++) begin
            m_abin[b] = 0;
            m_vbin[b] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == 32'h0)   return m_din;
        if (a == 32'h4)   return {31'b0, m_ctrl};
        if (a == 32'h100) return clamp(m_atot, 64'hFFFF_FFFF);
        if (a == 32'h104) return clamp(m_vtot, 64'hFFFF_FFFF);
        if (a == 32'h108) return clamp(m_aocc, 64'hFFFF_FFFF);
        if (a == 32'h10C) return clamp(m_vmax, 64'hFFFF);
        if (a == 32'h110) return clamp(m_vocc, 64'hFFFF_FFFF);
        if (a[1:0] == 2'b00 && a >= 32'h11000 && a < 32'h11040)
            return clamp(m_abin[(a - 32'h11000) >> 2], 64'hFFFF);
        if (a[1:0] == 2'b00 && a >= 32'h12000 && a < 32'h12040)
            return clamp(m_vbin[(a - 32'h12000) >> 2], 64'hFFFF);
        return 32'h0;
    endfunction

    function automatic void model_update(input bit rst, input bit wr, input logic [31:0] addr,
                                         input logic [31:0] data, input bit afr, input bit vw,
                                         input bit vr);
        bit     aev;
        longint g;
        if (rst) begin
            clear_stats();
            m_ctrl = 0; m_din = '0; m_pend = 0;
            cyc++;
            return;
        end
        aev = m_pend;
        if (m_ctrl) begin
            clear_stats();
        end else begin
            if (aev) begin
                m_atot++;
                if (m_alast >= 0) begin
                    g = (cyc - m_alast > 65535) ? 65535 : cyc - m_alast;
                    m_abin[bin_of(g)]++;
                end
                m_alast = cyc;
            end
            if (vw) begin
                m_vtot++;
                if (m_vlast >= 0) begin
                    g = (cyc - m_vlast > 65535) ? 65535 : cyc - m_vlast;
                    m_vbin[bin_of(g)]++;
                    if (g > m_vmax) m_vmax = g;
                end
                m_vlast = cyc;
            end
            m_aocc = occ(m_aocc, aev, afr);
            m_vocc = occ(m_vocc, vw, vr);
        end
        m_pend = wr && (addr == 32'h0);
        if (wr && addr == 32'h0) m_din = data;
        if (wr && addr == 32'h4) m_ctrl = data[0];
        cyc++;
    endfunction

    // One clock cycle of stimulus; expectations are queued before the edge that samples it.
    task automatic step(input bit rst, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit afr, input bit vw, input bit vr,
                        input bit cv = 1'b0, input logic [31:0] cval = 32'h0);
        reset = rst; slave_wr = wr; slave_rd = rd; slave_addr = addr; slave_data_in = data;
        addr_fifo_rd = afr; vctr_fifo_wr = vw; vctr_fifo_rd = vr;
        if (rd && !rst) rd_q.push_back('{addr, model_read(addr), cv, cval});
        if (wr && !rst && addr == 32'h0) din_q.push_back(data);
        model_update(rst, wr, addr, data, afr, vw, vr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, 0, a, d, 0, 0, 0);
    endtask

    task automatic do_rdc(input logic [31:0] a, input logic [31:0] v);
        step(0, 0, 1, a, 32'h0, 0, 0, 0, 1'b1, v);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h4;
            2:       return 32'h100;
            3:       return 32'h104;
            4:       return 32'h108;
            5:       return 32'h10C;
            6:       return 32'h110;
            7:       return 32'h11000 + ($urandom_range(0, 15) << 2);
            8:       return 32'h12000 + ($urandom_range(0, 15) << 2);
            default: return 32'h11040 + $urandom_range(0, 3);
        endcase
    endfunction

    always @(posedge clk) rd_due <= slave_rd && !reset;

    always @(negedge clk) begin
        if (rd_due) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL rd_unexpected: got 0x%08h expected no read", slave_data_out);
            end else begin
                mon_e = rd_q.pop_front();
                chk($sformatf("rd_model@%08h", mon_e.addr), slave_data_out, mon_e.exp);
                if (mon_e.cv) chk($sformatf("rd_spec@%08h", mon_e.addr), slave_data_out,
                                  mon_e.cval);
            end
        end
        if (addr_fifo_wr) begin
            if (din_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL push_unexpected: got pulse din 0x%08h expected no pulse",
                         addr_fifo_din);
            end else begin
                mon_d = din_q.pop_front();
                chk("push_din", addr_fifo_din, mon_d);
            end
        end
    end

    initial begin
        int          r;
        logic [31:0] a;
        bit          vw, vr, af;
        clear_stats();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("rst_data_out", slave_data_out, 32'h0);
        chk("rst_fifo_wr", {31'b0, addr_fifo_wr}, 32'h0);
        chk("rst_fifo_din", addr_fifo_din, 32'h0);
        do_rdc(32'h0, 0); do_rdc(32'h4, 0); do_rdc(32'h100, 0); do_rdc(32'h104, 0);
        do_rdc(32'h108, 0); do_rdc(32'h10C, 0); do_rdc(32'h110, 0);
        do_rdc(32'h11000, 0); do_rdc(32'h1203C, 0);

        // CTRL read-back
        do_wr(32'h4, 32'h1); do_rdc(32'h4, 32'h1);
        do_wr(32'h4, 32'h0); do_rdc(32'h4, 32'h0);

        // Single push
        do_wr(32'h0, 32'h1000); idle(1);
        do_rdc(32'h100, 1); do_rdc(32'h108, 1); do_rdc(32'h0, 32'h1000);

        // Vector pushes 17 then 8 cycles apart
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0); idle(16);
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0); idle(7);
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0); idle(1);
        do_rdc(32'h12008, 1); do_rdc(32'h12004, 1); do_rdc(32'h104, 3); do_rdc(32'h10C, 17);
        do_rdc(32'h110, 3);

        // Simultaneous push/pop and dual pops
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 1); do_rdc(32'h110, 3);
        step(0, 0, 0, 32'h0, 32'h0, 1, 0, 1); do_rdc(32'h108, 0); do_rdc(32'h110, 2);

        // Unmapped and unaligned accesses
        do_wr(32'h1, 32'hDEAD_BEEF); do_wr(32'h6, 32'h1); idle(1);
        do_rdc(32'h0, 32'h1000); do_rdc(32'h200, 0); do_rdc(32'h4, 0); do_rdc(32'h100, 1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            r  = int'($urandom_range(0, 99));
            af = ($urandom_range(0, 5) == 0);
            vw = ($urandom_range(0, 7) == 0);
            vr = ($urandom_range(0, 5) == 0);
            if (i == 1500)    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
            else if (r < 12)  step(0, 1, 0, 32'h0, $urandom, af, vw, vr);
            else if (r < 40)  begin a = rand_addr(); step(0, 0, 1, a, 32'h0, af, vw, vr); end
            else if (r == 40) step(0, 1, 0, 32'h4, 32'h1, af, vw, vr);
            else if (r < 43)  step(0, 1, 0, 32'h4, 32'h0, af, vw, vr);
            else if (r == 43) begin a = rand_addr(); step(0, 1, 0, a, $urandom, af, vw, vr); end
            else              step(0, 0, 0, 32'h0, 32'h0, af, vw, vr);
            if ($urandom_range(0, 49) == 0) idle(int'($urandom_range(16, 140)));
        end

        // Saturating gap after a long idle, then pops at empty
        do_wr(32'h4, 32'h1); do_wr(32'h4, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0); idle(65540);
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0); idle(1);
        do_rdc(32'h10C, 32'hFFFF); do_rdc(32'h1203C, 1); do_rdc(32'h104, 2); do_rdc(32'h110, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0, 1, 0, 1);
        do_rdc(32'h110, 0); do_rdc(32'h108, 0);

        // Reset right after a push
        do_wr(32'h0, 32'hABCD_0123);
        step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0); step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        chk("rst2_fifo_wr", {31'b0, addr_fifo_wr}, 32'h0);
        chk("rst2_fifo_din", addr_fifo_din, 32'h0);
        do_rdc(32'h0, 0); do_rdc(32'h4, 0); do_rdc(32'h100, 0); do_rdc(32'h104, 0);
        do_rdc(32'h108, 0); do_rdc(32'h10C, 0); do_rdc(32'h110, 0);
        do_rdc(32'h11004, 0); do_rdc(32'h1203C, 0);
        idle(3);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        chk("push_queue_drained", 32'(din_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
